// File: rtl/sram22_req_master.sv
// Request-side initiator for the 1024x64 byte-masked single-port SRAM macro.
// Turns a valid/ready request stream into SRAM port cycles and returns read data.
module sram22_req_master #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int WMASK_WIDTH  = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state;
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_rstb  <= 1'b0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      sram_rstb  <= 1'b1;
      // The SRAM port is a single-cycle pulse; addr/din keep their last values.
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      case (state)
        IDLE: begin
          // req_ready opens one edge after the SRAM leaves reset.
          if (sram_rstb) req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if (req_we) begin
              if (|req_wmask) begin
                sram_ce    <= 1'b1;
                sram_we    <= 1'b1;
                sram_wmask <= req_wmask;
                sram_addr  <= req_addr;
                sram_din   <= req_wdata;
              end
            end else begin
              sram_ce   <= 1'b1;
              sram_addr <= req_addr;
              cnt       <= LAT;
              req_ready <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // Capture one edge after dout becomes valid.
          if (cnt == 3'd0) begin
            rsp_rdata <= sram_dout;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram22_req_master.sv
// Bench for sram22_req_master: SRAM macro model, transaction-level scoreboard
// checked every cycle, and directed vectors with literal expectations.
module tb_sram22_req_master;

  localparam int RL = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        sram_rstb;
  logic        sram_ce;
  logic        sram_we;
  logic [7:0]  sram_wmask;
  logic [9:0]  sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout;

  sram22_req_master #(
    .DATA_WIDTH(64), .ADDR_WIDTH(10), .WMASK_WIDTH(8), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_rstb(sram_rstb), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: samples on the rising edge, read data after RL edges.
  logic [63:0] smem  [1024];
  logic [63:0] dpipe [RL];
  always @(posedge clk) begin
    for (int k = RL - 1; k > 0; k--) dpipe[k] <= dpipe[k-1];
    if (sram_ce && sram_we) begin
      for (int b = 0; b < 8; b++)
        if (sram_wmask[b]) smem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
    end else if (sram_ce) begin
      dpipe[0] <= smem[sram_addr];
    end
  end
  assign sram_dout = dpipe[RL-1];

  int errors = 0;
  int checks = 0;
  int ce_count = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard state.
  logic [63:0] refmem [1024];
  int          since;
  bit          outst;
  int          age;
  logic [63:0] exp_data;
  logic [9:0]  exp_addr;
  logic [63:0] exp_din;
  logic        prev_ready;
  logic        prev_rvalid;

  task automatic monitor();
    bit          acc;
    logic        e_ce, e_we, e_valid;
    logic [7:0]  e_wm;
    for (int i = 0; i < 1024; i++) refmem[i] = '0;
    since = 0; outst = 0; age = 0; exp_data = '0;
    exp_addr = '0; exp_din = '0; prev_ready = 1'b0; prev_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      acc = !rst && req_valid && prev_ready;
      if (rst) begin
        since = 0; outst = 0; exp_addr = '0; exp_din = '0;
        check("reset_outputs",
              {req_ready, rsp_valid, rsp_rdata, sram_rstb, sram_ce, sram_we,
               sram_wmask, sram_addr, sram_din}, '0);
      end else begin
        if (since < 3) since++;
        e_ce = 1'b0; e_we = 1'b0; e_wm = '0;
        if (outst) begin
          age++;
          if (prev_rvalid && rsp_ready) outst = 0;
        end
        if (acc) begin
          if (req_we) begin
            if (req_wmask != 8'h00) begin
              e_ce = 1'b1; e_we = 1'b1; e_wm = req_wmask;
              exp_addr = req_addr; exp_din = req_wdata;
              for (int b = 0; b < 8; b++)
                if (req_wmask[b]) refmem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end else begin
            e_ce = 1'b1; exp_addr = req_addr;
            outst = 1; age = 0; exp_data = refmem[req_addr];
          end
        end
        check("sram_port", {sram_rstb, sram_ce, sram_we, sram_wmask, sram_addr, sram_din},
              {1'b1, e_ce, e_we, e_wm, exp_addr, exp_din});
        check("req_ready", req_ready, (since >= 2) && !outst);
        e_valid = outst && (age >= RL + 1);
        check("rsp_valid", rsp_valid, e_valid);
        if (e_valid) check("rsp_rdata", rsp_rdata, exp_data);
      end
      prev_ready  = req_ready;
      prev_rvalid = rsp_valid;
      if (sram_ce) ce_count++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] m);
    int n;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (n >= 50) check("write_accept_timeout", 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, output logic [63:0] d, output int lat);
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wmask = '0;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (n >= 50) check("read_accept_timeout", 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    d = rsp_rdata;
    if (rsp_ready) step();
  endtask

  logic [63:0] d;
  int          lat;
  int          c0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) step();
    check("ready_in_reset", {req_ready, sram_rstb}, 2'b00);
    rst = 1'b0;
    step();
    check("rstb_after_reset", {sram_rstb, req_ready}, 2'b10);
    step();
    check("ready_after_reset", req_ready, 1'b1);

    // Full-mask write and read
    c0 = ce_count;
    do_write(10'd5, 64'hDEADBEEFCAFEBABE, 8'hFF);
    step(); step();
    check("full_write_ce_pulses", ce_count - c0, 1);
    do_read(10'd5, d, lat);
    check("full_read_latency", lat, 2);
    check("full_read_data", d, 64'hDEADBEEFCAFEBABE);

    // Partial mask
    do_write(10'd7, 64'h1111111111111111, 8'hFF);
    do_write(10'd7, 64'h2222222222222222, 8'h0F);
    do_read(10'd7, d, lat);
    check("partial_mask_data", d, 64'h1111111122222222);

    // Back-to-back writes
    step();
    req_valid = 1'b1; req_we = 1'b1; req_wmask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      req_addr = 10'(i); req_wdata = 64'(i + 1);
      check("b2b_ready", req_ready, 1'b1);
      step();
      check("b2b_ce", {sram_ce, sram_we}, 2'b11);
    end
    req_valid = 1'b0;
    step();
    check("b2b_ce_end", sram_ce, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_read(10'(i), d, lat);
      check("b2b_readback", d, 64'(i + 1));
    end

    // Backpressure
    rsp_ready = 1'b0;
    do_read(10'd5, d, lat);
    c0 = ce_count;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b0, 64'hDEADBEEFCAFEBABE});
    end
    check("bp_no_ce", ce_count - c0, 0);
    rsp_ready = 1'b1;
    step();
    check("bp_release", {rsp_valid, req_ready}, 2'b01);

    // Zero-mask write
    c0 = ce_count;
    do_write(10'd5, 64'h0123456789ABCDEF, 8'h00);
    step();
    check("zero_mask_no_ce", ce_count - c0, 0);
    do_read(10'd5, d, lat);
    check("zero_mask_old_data", d, 64'hDEADBEEFCAFEBABE);

    // Reset in the WAIT cycle
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    step();
    req_valid = 1'b0;
    check("midrst_in_wait", {sram_ce, req_ready, rsp_valid}, 3'b100);
    rst = 1'b1;
    step();
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst_no_rsp", rsp_valid, 1'b0);
    end
    do_read(10'd5, d, lat);
    check("midrst_readback", d, 64'hDEADBEEFCAFEBABE);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
